// File: rtl/uart_cmd_parser.sv
// Decodes SYNC/ADDR/DATA_HI/DATA_LO/CHK register-write frames from the UART receiver,
// strobes accepted writes into the PID register file and offers an ACK/NAK byte back.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         NUM_REGS    = 16,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] ACK_BYTE    = 8'h06,
  parameter logic [7:0] NAK_BYTE    = 8'h15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_framing_error,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  err_count
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0]       NREGS    = 9'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, S_ADDR, S_DHI, S_DLO, S_CHK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       addr_p0, dhi_p0, dlo_p0;
  logic [7:0]       sum_p0;
  logic             in_frame, byte_ok, abort, timeout, frame_done, frame_good;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    in_frame   = (state_q != IDLE);
    byte_ok    = rx_valid && !rx_framing_error;
    abort      = in_frame && rx_framing_error;
    // A byte arriving on the last allowed cycle keeps the frame alive.
    timeout    = in_frame && !rx_valid && !rx_framing_error && (cnt_q == CNT_LAST);
    sum_p0     = addr_p0 + dhi_p0 + dlo_p0;
    frame_done = (state_q == S_CHK) && byte_ok;
    frame_good = (sum_p0 == rx_data) && ({1'b0, addr_p0} < NREGS);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (rx_valid && rx_data == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR:  if (byte_ok) state_d = S_DHI;
      S_DHI:   if (byte_ok) state_d = S_DLO;
      S_DLO:   if (byte_ok) state_d = S_CHK;
      S_CHK:   if (byte_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort || timeout) state_d = IDLE;
  end

  // Stage p0: capture frame fields as they arrive
  always_ff @(posedge clk) begin
    if (byte_ok) begin
      case (state_q)
        S_ADDR:  addr_p0 <= rx_data;
        S_DHI:   dhi_p0  <= rx_data;
        S_DLO:   dlo_p0  <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (rx_valid || !in_frame || abort || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Stage p1: write strobe, response and error bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      err_count <= '0;
    end else begin
      wr_en <= frame_done && frame_good;
      if (frame_done && frame_good) begin
        wr_addr <= addr_p0;
        wr_data <= {dhi_p0, dlo_p0};
      end
      if (frame_done) begin
        tx_valid <= 1'b1;
        tx_data  <= frame_good ? ACK_BYTE : NAK_BYTE;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if ((frame_done && !frame_good) || abort || timeout)
        err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: vector table, hand-written corner sequences and random frames
// checked against a frame-level reference model.
module tb_uart_cmd_parser;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_framing_error;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;
  int ec    = 0;

  logic [23:0] wr_q[$];
  logic [7:0]  tx_q[$];

  typedef struct {
    logic [39:0] frame;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  resp;
    int          einc;
  } vec_t;

  vec_t vt[6];

  uart_cmd_parser #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_framing_error(rx_framing_error), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Record write strobes and accepted response bytes (handshake lands on the next rising edge)
  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int g);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc(1);
    rx_valid = 1'b0;
    cyc(g);
  endtask

  task automatic send_frame(input logic [39:0] f, input int g);
    for (int j = 4; j >= 0; j--) send_byte(f[j*8 +: 8], g);
  endtask

  task automatic expect_frame(input string nm, input bit wr, input logic [7:0] a,
                              input logic [15:0] d, input logic [7:0] resp);
    cyc(3);
    chk({nm, "_nwr"}, wr_q.size(), {31'd0, wr});
    if (wr_q.size() != 0) chk({nm, "_wr"}, wr_q.pop_front(), {a, d});
    chk({nm, "_ntx"}, tx_q.size(), 1);
    if (tx_q.size() != 0) chk({nm, "_tx"}, tx_q.pop_front(), resp);
    chk({nm, "_err"}, err_count, ec);
    wr_q.delete();
    tx_q.delete();
  endtask

  function automatic logic [39:0] mk(input logic [7:0] a, input logic [7:0] h,
                                     input logic [7:0] l, input logic [7:0] c);
    return {8'hA5, a, h, l, c};
  endfunction

  initial begin
    vt[0] = '{40'hA5_01_12_34_47, 1'b1, 8'h01, 16'h1234, 8'h06, 0};
    vt[1] = '{40'hA5_01_12_34_48, 1'b0, 8'h00, 16'h0000, 8'h15, 1};
    vt[2] = '{40'hA5_20_00_01_21, 1'b0, 8'h00, 16'h0000, 8'h15, 1};
    vt[3] = '{40'hA5_0F_FF_FF_0D, 1'b1, 8'h0F, 16'hFFFF, 8'h06, 0};
    vt[4] = '{40'hA5_10_00_00_10, 1'b0, 8'h00, 16'h0000, 8'h15, 1};
    vt[5] = '{40'hA5_00_00_00_00, 1'b1, 8'h00, 16'h0000, 8'h06, 0};

    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; rx_framing_error = 1'b0; tx_ready = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_outs", {wr_en, tx_valid, wr_addr, tx_data, err_count}, 0);
    chk("rst_wdata", wr_data, 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].frame, 1);
      ec += vt[i].einc;
      expect_frame($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].data, vt[i].resp);
    end
    chk("hold_addr", wr_addr, 8'h00);
    chk("tx_drop", tx_valid, 0);

    // Leading junk ignored, SYNC value inside the frame is payload
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_frame(40'hA5_03_A5_00_A8, 1);
    expect_frame("junk", 1'b1, 8'h03, 16'hA500, 8'h06);

    // Inter-byte timeout
    send_byte(8'hA5, 1);
    send_byte(8'h02, 1);
    cyc(TO + 20);
    ec++;
    chk("to_err", err_count, ec);
    chk("to_nwr", wr_q.size(), 0);
    chk("to_ntx", tx_q.size(), 0);
    send_frame(40'hA5_02_00_07_09, 1);
    expect_frame("to_after", 1'b1, 8'h02, 16'h0007, 8'h06);
    send_frame(40'hA5_04_00_01_05, TO - 1);
    expect_frame("to_edge", 1'b1, 8'h04, 16'h0001, 8'h06);
    send_byte(8'hA5, TO);
    send_byte(8'h02, 1);
    ec++;
    cyc(3);
    chk("to_late_err", err_count, ec);
    chk("to_late_nwr", wr_q.size(), 0);

    // Response held while the transmitter is busy
    tx_ready = 1'b0;
    send_frame(40'hA5_05_00_01_06, 1);
    begin
      int held = 0;
      for (int k = 0; k < 50; k++) begin
        if (tx_valid && tx_data == 8'h06) held++;
        cyc(1);
      end
      chk("hold_cycles", held, 50);
    end
    tx_ready = 1'b1;
    cyc(1);
    chk("hold_drop", tx_valid, 0);
    chk("hold_ntx", tx_q.size(), 1);
    chk("hold_nwr", wr_q.size(), 1);
    wr_q.delete(); tx_q.delete();

    // Pending response overwritten by a newer frame
    tx_ready = 1'b0;
    send_frame(40'hA5_06_00_00_06, 1);
    send_frame(40'hA5_06_00_00_07, 1);
    ec++;
    chk("ovw_valid", tx_valid, 1);
    chk("ovw_data", tx_data, 8'h15);
    tx_ready = 1'b1;
    cyc(2);
    chk("ovw_ntx", tx_q.size(), 1);
    chk("ovw_err", err_count, ec);
    wr_q.delete(); tx_q.delete();

    // Framing error aborts a frame and discards the coincident byte
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    rx_framing_error = 1'b1; rx_valid = 1'b1; rx_data = 8'h12;
    cyc(1);
    rx_framing_error = 1'b0; rx_valid = 1'b0;
    ec++;
    send_byte(8'h34, 1);
    send_byte(8'h47, 1);
    cyc(3);
    chk("fe_err", err_count, ec);
    chk("fe_nwr", wr_q.size(), 0);
    chk("fe_ntx", tx_q.size(), 0);
    rx_framing_error = 1'b1;
    cyc(2);
    rx_framing_error = 1'b0;
    chk("fe_idle", err_count, ec);

    // Random frames against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a, h, l, c, j;
      bit good;
      int g;
      g = $urandom_range(0, 5);
      repeat ($urandom_range(0, 3)) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h00;
        send_byte(j, g);
      end
      a = 8'($urandom_range(0, 31));
      h = 8'($urandom);
      l = 8'($urandom);
      c = a + h + l;
      if ($urandom_range(0, 2) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      good = (c == 8'((int'(a) + int'(h) + int'(l)) % 256)) && (int'(a) < 16);
      if (!good) ec++;
      send_frame(mk(a, h, l, c), g);
      expect_frame($sformatf("rnd%0d", n), good, a, {h, l}, good ? 8'h06 : 8'h15);
    end

    // Reset mid-frame with a response pending
    tx_ready = 1'b0;
    send_frame(40'hA5_07_00_02_09, 1);
    send_byte(8'hA5, 1);
    send_byte(8'h01, 1);
    reset = 1'b1;
    #1;
    chk("mr_ctl", {wr_en, tx_valid}, 0);
    chk("mr_addr", wr_addr, 0);
    chk("mr_data", wr_data, 0);
    chk("mr_tx", tx_data, 0);
    chk("mr_err", err_count, 0);
    cyc(1);
    reset = 1'b0;
    ec = 0;
    wr_q.delete(); tx_q.delete();
    tx_ready = 1'b1;
    send_frame(40'hA5_01_12_34_47, 1);
    expect_frame("mr_after", 1'b1, 8'h01, 16'h1234, 8'h06);

    // Error counter saturation
    for (int n = 0; n < 300; n++) begin
      send_frame(40'hA5_01_00_00_00, 0);
      ec = (ec >= 255) ? 255 : ec + 1;
      expect_frame($sformatf("sat%0d", n), 1'b0, 8'h00, 16'h0000, 8'h15);
    end
    chk("sat_final", err_count, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
